// File: rtl/move_pkg.sv
// Shared move definitions: direction encoding used by the board engine and
// the bit positions of the debounced direction buttons.
package move_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_DOWN  = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_RIGHT = 2'b11
   } dir_t;

   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;

   // Number of set bits beyond the first, i.e. presses lost to arbitration.
   function automatic logic [1:0] loser_count(input logic [3:0] pressed);
      int n;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         n = n + int'(pressed[i]);
      end
      return (n == 0) ? 2'd0 : 2'(n - 1);
   endfunction

endpackage

// File: rtl/move_cmd_queue_if.sv
// Valid/ready command channel from the move queue to the board-update FSM.
interface move_cmd_queue_if;
   import move_pkg::*;

   logic cmd_valid;
   logic cmd_ready;
   dir_t cmd_dir;

   modport master (output cmd_valid, output cmd_dir, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_dir, output cmd_ready);

endinterface

// File: rtl/move_prio_enc.sv
// Fixed-priority encoder for same-cycle button pulses: up wins, then down,
// left, right. Also reports how many other presses lost that cycle.
module move_prio_enc
   import move_pkg::*;
(
   input  logic [3:0] pressed,
   output logic       hit,
   output dir_t       dir,
   output logic [1:0] losers
);

   always_comb begin
      hit    = |pressed;
      dir    = DIR_UP;
      losers = loser_count(pressed);
      if (pressed[BTN_UP]) begin
         dir = DIR_UP;
      end else if (pressed[BTN_DOWN]) begin
         dir = DIR_DOWN;
      end else if (pressed[BTN_LEFT]) begin
         dir = DIR_LEFT;
      end else if (pressed[BTN_RIGHT]) begin
         dir = DIR_RIGHT;
      end
   end

endmodule

// File: rtl/move_cmd_queue.sv
// Button-pulse to move-command FIFO with valid/ready output.
// Optional dropped-press counter enabled by defining MOVE_CMD_DROP_CNT_EN.
module move_cmd_queue
   import move_pkg::*;
#(
   parameter int DEPTH  = 4
`ifdef MOVE_CMD_DROP_CNT_EN
   ,parameter int DROP_W = 8
`endif
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       btn_pressed,
   move_cmd_queue_if.master cmd,
   output logic             full
`ifdef MOVE_CMD_DROP_CNT_EN
   ,output logic [DROP_W-1:0] drop_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic       hit;
   dir_t       cand_dir;
   logic [1:0] losers;

   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;
   dir_t          mem [DEPTH];

   logic empty;
   logic push;
   logic pop;

   move_prio_enc u_prio (
      .pressed (btn_pressed),
      .hit     (hit),
      .dir     (cand_dir),
      .losers  (losers)
   );

   // Extra pointer MSB distinguishes a full ring from an empty one.
   assign wr_idx = wr_ptr[AW-1:0];
   assign rd_idx = rd_ptr[AW-1:0];
   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);

   assign pop  = !empty && cmd.cmd_ready;
   assign push = hit && (!full || pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // Storage is not reset; only the pointers decide what is live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_idx] <= cand_dir;
      end
   end

   assign cmd.cmd_valid = !empty;
   assign cmd.cmd_dir   = empty ? DIR_UP : mem[rd_idx];

`ifdef MOVE_CMD_DROP_CNT_EN
   logic [2:0]      dropped;
   logic [DROP_W:0] drop_sum;

   assign dropped  = {1'b0, losers} + {2'b00, (hit && !push)};
   assign drop_sum = {1'b0, drop_cnt} + (DROP_W+1)'(dropped);

   // Saturate rather than wrap so a stuck button cannot hide behind a rollover.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (drop_sum[DROP_W]) begin
         drop_cnt <= '1;
      end else begin
         drop_cnt <= drop_sum[DROP_W-1:0];
      end
   end
`else
   logic unused_losers;
   assign unused_losers = ^losers;
`endif

endmodule
